sccb_slave: RTL and testbench

Single-target SCCB responder for the camera path's 3-wire bus (`sdioc`, `sdiod`, `cs`). It oversamples the bus with the fabric clock, decodes write and read transactions addressed to its ID, and exposes a simple register-port interface to a local register bank. It is the bench-side and on-chip counterpart used to exercise the SCCB master without a physical sensor.

---
 rtl/sccb_slave.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sccb_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave.sv
// SCCB 3-wire responder: oversamples sdioc/sdiod/cs on the fabric clock, decodes
// write and read frames addressed to SLAVE_ADDR and drives a simple register port.
module sccb_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdioc,
  input  logic       cs,
  inout  wire logic  sdiod,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       wr_strobe,
  output logic       rd_strobe,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_RW, S_DNC1, S_SUB, S_DNC2,
    S_WDATA, S_RDATA, S_DNC3, S_WAIT_STOP, S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [2:0] dat_sync_q, dat_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       rw_q, rw_d;
  logic       sdo_q, sdo_d;
  logic       match_q, match_d;
  logic       fetch_q, fetch_d;
  logic       last_q, last_d;
  logic       oe_q, oe_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       scl, sda, cs_s;
  logic       rise, fall, sda_rise, cs_fall;
  logic       start, stop, abortable;
  logic [7:0] shift_src;

  // Bit [1] is the synchronized level, bit [2] its one-cycle-old copy for edges.
  assign scl      = clk_sync_q[1];
  assign sda      = dat_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign rise     = clk_sync_q[1] & ~clk_sync_q[2];
  assign fall     = ~clk_sync_q[1] & clk_sync_q[2];
  assign sda_rise = dat_sync_q[1] & ~dat_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign start    = cs_fall & scl;
  assign stop     = sda_rise & scl;

  assign sdiod     = oe_q ? sdo_q : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], sdioc};
    dat_sync_d = {dat_sync_q[1:0], sdiod};
    cs_sync_d  = {cs_sync_q[1:0], cs};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rw_d        = rw_q;
    sdo_d       = sdo_q;
    match_d     = match_q;
    last_d      = last_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fetch_d     = rd_strobe_q;

    // Read data may arrive in the same clk as the first fall; forward it.
    shift_src = fetch_q ? reg_rdata : shift_q;
    if (fetch_q) shift_d = reg_rdata;

    abortable = (state_q != S_IDLE) && (state_q != S_WAIT_STOP) &&
                (state_q != S_IGNORE);

    if (abortable && cs_s) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      err_d   = match_q;
      match_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ID;
            cnt_d   = 3'd6;
            busy_d  = 1'b1;
            match_d = 1'b0;
            last_d  = 1'b0;
          end
        end
        S_ID: begin
          if (rise) begin
            shift_d = {shift_q[6:0], sda};
            if (cnt_q == 3'd0) state_d = S_RW;
            else               cnt_d   = cnt_q - 3'd1;
          end
        end
        S_RW: begin
          if (rise) begin
            rw_d = sda;
            if (shift_q[6:0] == SLAVE_ADDR) begin
              match_d = 1'b1;
              state_d = S_DNC1;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_DNC1: begin
          if (rise) begin
            state_d = S_SUB;
            cnt_d   = 3'd7;
          end
        end
        S_SUB: begin
          if (rise) begin
            shift_d = {shift_q[6:0], sda};
            if (cnt_q == 3'd0) begin
              reg_addr_d = {shift_q[6:0], sda};
              state_d    = S_DNC2;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        S_DNC2: begin
          if (rise) begin
            cnt_d = 3'd7;
            if (rw_q) begin
              rd_strobe_d = 1'b1;
              last_d      = 1'b0;
              state_d     = S_RDATA;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (rise) begin
            shift_d = {shift_q[6:0], sda};
            if (cnt_q == 3'd0) begin
              reg_wdata_d = {shift_q[6:0], sda};
              wr_strobe_d = 1'b1;
              state_d     = S_DNC3;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        S_RDATA: begin
          // Each fall presents the next bit; the fall after the 8th rise releases.
          if (fall) begin
            if (last_q) begin
              oe_d    = 1'b0;
              state_d = S_DNC3;
            end else begin
              oe_d    = 1'b1;
              sdo_d   = shift_src[7];
              shift_d = {shift_src[6:0], 1'b0};
            end
          end else if (rise) begin
            if (cnt_q == 3'd0) last_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end
        end
        S_DNC3: begin
          if (rise) state_d = S_WAIT_STOP;
        end
        S_WAIT_STOP: begin
          if (stop) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            match_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_IGNORE: begin
          if (stop || cs_s) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      match_q     <= 1'b0;
      fetch_q     <= 1'b0;
      last_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      match_q     <= match_d;
      fetch_q     <= fetch_d;
      last_q      <= last_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    clk_sync_q <= clk_sync_d;
    dat_sync_q <= dat_sync_d;
    cs_sync_q  <= cs_sync_d;
    shift_q    <= shift_d;
    rw_q       <= rw_d;
    sdo_q      <= sdo_d;
  end

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a bit-banged SCCB master, a one-shot register
// bank model and negedge monitors that tally strobes, done/err pulses and drive.
module tb_sccb_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sdioc = 1'b1;
  logic       cs = 1'b1;
  logic       m_oe = 1'b1;
  logic       m_do = 1'b1;
  wire        sdiod;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       wr_strobe, rd_strobe, busy, done, err;
  logic [7:0] bank_val = 8'h00;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, drive_cnt = 0;
  logic [7:0] wr_addr_log [4];
  logic [7:0] wr_data_log [4];
  logic [7:0] rd_addr_log [4];

  assign sdiod = m_oe ? m_do : 1'bz;

  sccb_slave #(.SLAVE_ADDR(7'h21)) dut (
    .clk       (clk),
    .reset     (reset),
    .sdioc     (sdioc),
    .cs        (cs),
    .sdiod     (sdiod),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Bank returns data only in the clk right after rd_strobe.
  always @(posedge clk) reg_rdata <= rd_strobe ? bank_val : 8'h00;

  always @(negedge clk) begin
    if (wr_strobe) begin
      if (wr_cnt < 4) begin
        wr_addr_log[wr_cnt] = reg_addr;
        wr_data_log[wr_cnt] = reg_wdata;
      end
      wr_cnt++;
    end
    if (rd_strobe) begin
      if (rd_cnt < 4) rd_addr_log[rd_cnt] = reg_addr;
      rd_cnt++;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (dut.oe_q) drive_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdioc = 1'b0;
    tick(2);
    m_oe = 1'b1;
    m_do = b;
    tick(2);
    sdioc = 1'b1;
    tick(4);
  endtask

  task automatic send_bits(input logic [7:0] v, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(v[i]);
  endtask

  task automatic header(input logic [6:0] id, input logic rw, input logic [7:0] sub);
    cs = 1'b0;
    tick(4);
    for (int i = 6; i >= 0; i--) send_bit(id[i]);
    send_bit(rw);
    send_bit(1'b1);
    send_bits(sub, 8);
    send_bit(1'b0);
  endtask

  task automatic read_bits(input int nbits, output logic [7:0] v);
    v = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdioc = 1'b0;
      tick(4);
      v = {v[6:0], sdiod};
      sdioc = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_stop();
    sdioc = 1'b0;
    tick(4);
    m_oe = 1'b1;
    m_do = 1'b0;
    tick(2);
    sdioc = 1'b1;
    tick(4);
    m_do = 1'b1;
    tick(6);
  endtask

  task automatic release_cs();
    cs = 1'b1;
    tick(4);
  endtask

  task automatic write_txn(input logic [6:0] id, input logic [7:0] sub, input logic [7:0] data);
    header(id, 1'b0, sub);
    send_bits(data, 8);
    send_bit(1'b1);
    send_stop();
    release_cs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rv;
    int drv_snap;

    reset = 1'b0;
    tick(6);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_rd_strobe", rd_strobe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done_err", {done, err}, 0);
    check_eq("rst_reg_addr", reg_addr, 0);
    check_eq("rst_reg_wdata", reg_wdata, 0);
    check_eq("rst_sdiod_released", dut.oe_q, 0);
    reset = 1'b1;
    tick(4);

    // Write 0x80 to 0x12
    header(7'h21, 1'b0, 8'h12);
    check_eq("wr_busy_mid", busy, 1);
    send_bits(8'h80, 8);
    check_eq("wr_strobe_count", wr_cnt, 1);
    send_bit(1'b1);
    send_stop();
    check_eq("wr_busy_after_stop", busy, 0);
    release_cs();
    check_eq("wr_addr", wr_addr_log[0], 8'h12);
    check_eq("wr_data", wr_data_log[0], 8'h80);
    check_eq("wr_reg_addr_out", reg_addr, 8'h12);
    check_eq("wr_done_count", done_cnt, 1);
    check_eq("wr_no_rd_err", rd_cnt + err_cnt, 0);
    check_eq("wr_never_drove", drive_cnt, 0);

    // Read 0x0A, bank answers 0x76
    bank_val = 8'h76;
    header(7'h21, 1'b1, 8'h0A);
    m_oe = 1'b0;
    read_bits(8, rv);
    check_eq("rd_data", rv, 8'h76);
    check_eq("rd_strobe_count", rd_cnt, 1);
    check_eq("rd_addr", rd_addr_log[0], 8'h0A);
    sdioc = 1'b0;
    tick(4);
    check_eq("rd_released", dut.oe_q, 0);
    sdioc = 1'b1;
    tick(4);
    send_stop();
    check_eq("rd_done_count", done_cnt, 2);
    check_eq("rd_no_wr", wr_cnt, 1);
    release_cs();

    // Wrong ID 0x30
    drv_snap = drive_cnt;
    header(7'h30, 1'b0, 8'h12);
    check_eq("wid_busy_mid", busy, 1);
    send_bits(8'h55, 8);
    send_bit(1'b1);
    send_stop();
    check_eq("wid_busy_after_stop", busy, 0);
    release_cs();
    check_eq("wid_no_wr", wr_cnt, 1);
    check_eq("wid_no_rd", rd_cnt, 1);
    check_eq("wid_no_done", done_cnt, 2);
    check_eq("wid_no_err", err_cnt, 0);
    check_eq("wid_never_drove", drive_cnt, drv_snap);

    // Abort after 4 DATA bits
    header(7'h21, 1'b0, 8'h33);
    send_bits(8'hF0, 4);
    cs = 1'b1;
    tick(6);
    check_eq("abort_no_wr", wr_cnt, 1);
    check_eq("abort_err_count", err_cnt, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_no_done", done_cnt, 2);

    // Back-to-back writes
    write_txn(7'h21, 8'h01, 8'hAA);
    write_txn(7'h21, 8'h02, 8'h55);
    check_eq("b2b_wr_count", wr_cnt, 3);
    check_eq("b2b_first", {wr_addr_log[1], wr_data_log[1]}, 16'h01AA);
    check_eq("b2b_second", {wr_addr_log[2], wr_data_log[2]}, 16'h0255);
    check_eq("b2b_done_count", done_cnt, 4);

    // Reset in the middle of a read
    bank_val = 8'h3C;
    header(7'h21, 1'b1, 8'h0A);
    m_oe = 1'b0;
    read_bits(3, rv);
    check_eq("mid_rd_bits", rv, 8'h01);
    check_eq("mid_rd_driving", dut.oe_q, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_released", dut.oe_q, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_regs", {reg_addr, reg_wdata}, 16'h0000);
    check_eq("mid_rst_pulses", {wr_strobe, rd_strobe, done, err}, 0);
    reset = 1'b1;
    m_oe = 1'b1;
    m_do = 1'b1;
    release_cs();
    write_txn(7'h21, 8'h01, 8'h55);
    check_eq("post_rst_wr_count", wr_cnt, 4);
    check_eq("post_rst_wr", {wr_addr_log[3], wr_data_log[3]}, 16'h0155);
    check_eq("post_rst_done_count", done_cnt, 5);
    check_eq("post_rst_rd_err", {rd_cnt[7:0], err_cnt[7:0]}, 16'h0201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
